// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scroll controller: register map,
// CTRL bit positions, blank pattern and the hex-to-segment table.
package seg7_pkg;

    // Avalon word addresses of the four registers.
    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_CTRL   = 2'd1,
        ADDR_PERIOD = 2'd2,
        ADDR_STATUS = 2'd3
    } reg_addr_e;

    // Bit positions inside the CTRL register.
    localparam int CTRL_EN     = 0;
    localparam int CTRL_BLINK  = 1;
    localparam int CTRL_SCROLL = 2;
    localparam int CTRL_DIR    = 3;
    localparam int CTRL_DP_LSB = 8;

    // All segments and the decimal point off (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns; entry k is hex digit k
    // (entry 0 is the rightmost element of the concatenation).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex_in,
    output logic [6:0] seg_n
);

    // Straight table lookup; the table already holds active-low patterns.
    always_comb begin
        seg_n = HEX_SEG_TABLE[hex_in];
    end

endmodule

// File: rtl/seg7_scroll_ctrl.sv
// Avalon-MM slave driving up to eight seven-segment digits. Holds the hex
// nibbles, a control word and a tick period; the tick generator drives
// blinking (phase) and circular scrolling (offset) of the displayed digits.
// NUM_DIGITS must stay within 1..8 because the offset register is 3 bits.
module seg7_scroll_ctrl
    import seg7_pkg::*;
#(
    parameter int          NUM_DIGITS     = 6,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [8*NUM_DIGITS-1:0] seg7_export
);

    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    reg_addr_e addr;

    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic                    en_q, en_d;
    logic                    blink_q, blink_d;
    logic                    scroll_q, scroll_d;
    logic                    dir_q, dir_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [31:0]             period_q, period_d;
    logic [31:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]              offset_q, offset_d;
    logic                    phase_q, phase_d;
    logic [31:0]             readdata_q, readdata_d;
    logic [8*NUM_DIGITS-1:0] export_q, export_d;

    logic        wr_data, wr_ctrl, wr_period, status_clr;
    logic [31:0] period_m1;
    logic        tick;
    logic [2:0]  offset_step;
    logic [31:0] ctrl_rd;
    logic        blank;

    logic [3:0] rot_nib [NUM_DIGITS];
    logic [6:0] seg_raw [NUM_DIGITS];

    assign addr = reg_addr_e'(avs_address);

    // Decode write strobes and generate the tick from the pre-write counter/period.
    always_comb begin
        wr_data    = avs_write && (addr == ADDR_DATA);
        wr_ctrl    = avs_write && (addr == ADDR_CTRL);
        wr_period  = avs_write && (addr == ADDR_PERIOD);
        status_clr = avs_write && (addr == ADDR_STATUS) && avs_writedata[0];
        period_m1  = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;
        tick       = (tick_cnt_q >= period_m1);
        if (dir_q) begin
            offset_step = (offset_q == 3'd0) ? LAST_DIGIT : offset_q - 3'd1;
        end else begin
            offset_step = (offset_q == LAST_DIGIT) ? 3'd0 : offset_q + 3'd1;
        end
    end

    // Next register state: tick effects first, then writes, then STATUS clear wins over all.
    always_comb begin
        data_d     = data_q;
        en_d       = en_q;
        blink_d    = blink_q;
        scroll_d   = scroll_q;
        dir_d      = dir_q;
        dp_d       = dp_q;
        period_d   = period_q;
        tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
        offset_d   = (tick && scroll_q) ? offset_step : offset_q;
        phase_d    = blink_q ? (phase_q ^ tick) : 1'b0;
        if (wr_data) begin
            data_d = avs_writedata[4*NUM_DIGITS-1:0];
        end
        if (wr_ctrl) begin
            en_d     = avs_writedata[CTRL_EN];
            blink_d  = avs_writedata[CTRL_BLINK];
            scroll_d = avs_writedata[CTRL_SCROLL];
            dir_d    = avs_writedata[CTRL_DIR];
            dp_d     = avs_writedata[CTRL_DP_LSB +: NUM_DIGITS];
        end
        if (wr_period) begin
            period_d   = avs_writedata;
            tick_cnt_d = 32'd0;
        end
        if (status_clr) begin
            offset_d   = 3'd0;
            phase_d    = 1'b0;
            tick_cnt_d = 32'd0;
        end
    end

    // Read mux; the result is captured only on a read strobe and held otherwise.
    always_comb begin
        ctrl_rd                                 = 32'd0;
        ctrl_rd[CTRL_EN]                        = en_q;
        ctrl_rd[CTRL_BLINK]                     = blink_q;
        ctrl_rd[CTRL_SCROLL]                    = scroll_q;
        ctrl_rd[CTRL_DIR]                       = dir_q;
        ctrl_rd[CTRL_DP_LSB +: NUM_DIGITS]      = dp_q;
        readdata_d                              = readdata_q;
        if (avs_read) begin
            case (addr)
                ADDR_DATA:   readdata_d = 32'(data_q);
                ADDR_CTRL:   readdata_d = ctrl_rd;
                ADDR_PERIOD: readdata_d = period_q;
                ADDR_STATUS: readdata_d = {23'd0, phase_q, 5'd0, offset_q};
                default:     readdata_d = 32'd0;
            endcase
        end
    end

    // Rotate the nibbles so digit i shows nibble (i + offset) mod NUM_DIGITS.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            int sel;
            sel = i + int'(offset_q);
            if (sel >= NUM_DIGITS) begin
                sel = sel - NUM_DIGITS;
            end
            rot_nib[i] = data_q[4*sel +: 4];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_hex_decode u_dec (
            .hex_in (rot_nib[g]),
            .seg_n  (seg_raw[g])
        );
    end

    // Compose each digit byte, blanking the whole display when disabled or in the off blink phase.
    always_comb begin
        blank = !en_q || (blink_q && phase_q);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            export_d[8*i +: 8] = blank ? SEG_BLANK : {~dp_q[i], seg_raw[i]};
        end
    end

    // State, read-data and export registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            en_q       <= 1'b0;
            blink_q    <= 1'b0;
            scroll_q   <= 1'b0;
            dir_q      <= 1'b0;
            dp_q       <= '0;
            period_q   <= DEFAULT_PERIOD;
            tick_cnt_q <= 32'd0;
            offset_q   <= 3'd0;
            phase_q    <= 1'b0;
            readdata_q <= 32'd0;
            export_q   <= '1;
        end else begin
            data_q     <= data_d;
            en_q       <= en_d;
            blink_q    <= blink_d;
            scroll_q   <= scroll_d;
            dir_q      <= dir_d;
            dp_q       <= dp_d;
            period_q   <= period_d;
            tick_cnt_q <= tick_cnt_d;
            offset_q   <= offset_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
            export_q   <= export_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign seg7_export  = export_q;

endmodule

// File: tb/tb_seg7_scroll_ctrl.sv
// Self-checking bench for seg7_scroll_ctrl: directed scenarios plus random
// register traffic, all compared against a cycle-level behavioural model.
module tb_seg7_scroll_ctrl;

    localparam int          N       = 6;
    localparam logic [31:0] DEF_PER = 32'd50000000;
    localparam logic [1:0]  A_DATA = 2'd0, A_CTRL = 2'd1, A_PER = 2'd2, A_STAT = 2'd3;
    localparam logic [31:0] CTRL_MASK = 32'h0000_3F0F;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [47:0] seg7_export;

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    logic [6:0]  segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0]  mNib [N];
    logic [31:0] mCtrl;
    logic [31:0] mPeriod;
    longint      mCnt;
    int          mOffset;
    bit          mPhase;
    logic [31:0] mRd;
    logic [47:0] mExp;

    seg7_scroll_ctrl #(.NUM_DIGITS(N), .DEFAULT_PERIOD(DEF_PER)) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .seg7_export   (seg7_export)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        fails++;
        $display("[TB] FAIL %s: wait bound expired", tag);
    endtask

    function automatic void modelReset();
        for (int k = 0; k < N; k++) mNib[k] = 4'h0;
        mCtrl   = 32'd0;
        mPeriod = DEF_PER;
        mCnt    = 0;
        mOffset = 0;
        mPhase  = 1'b0;
        mRd     = 32'd0;
        mExp    = '1;
    endfunction

    // What the display should show for the current model state
    function automatic logic [47:0] modelDisplay();
        logic [47:0] r;
        int          idx;
        r = '1;
        for (int i = 0; i < N; i++) begin
            idx = (i + mOffset) % N;
            if (!mCtrl[0] || (mCtrl[1] && mPhase)) r[8*i +: 8] = 8'hFF;
            else r[8*i +: 8] = {~mCtrl[8+i], segTab[mNib[idx]]};
        end
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            A_DATA:  for (int k = 0; k < N; k++) r[4*k +: 4] = mNib[k];
            A_CTRL:  r = mCtrl;
            A_PER:   r = mPeriod;
            default: begin r[8] = mPhase; r[2:0] = 3'(mOffset); end
        endcase
        return r;
    endfunction

    // Advance model and DUT by one clock, then compare both outputs
    task automatic stepCycle();
        logic [47:0] nextExp;
        logic [3:0]  nNib [N];
        logic [31:0] nCtrl, nPer;
        longint      p, nCnt;
        int          nOff;
        bit          tick, nPh;
        nextExp = modelDisplay();
        if (avs_read) mRd = modelRead(avs_address);
        p    = (mPeriod == 0) ? 1 : longint'(mPeriod);
        tick = (mCnt >= p - 1);
        nCnt = tick ? 0 : mCnt + 1;
        nOff = mOffset;
        if (tick && mCtrl[2]) nOff = mCtrl[3] ? (mOffset + N - 1) % N : (mOffset + 1) % N;
        nPh  = mCtrl[1] ? (tick ? !mPhase : mPhase) : 1'b0;
        nNib  = mNib;
        nCtrl = mCtrl;
        nPer  = mPeriod;
        if (avs_write) begin
            case (avs_address)
                A_DATA: for (int k = 0; k < N; k++) nNib[k] = avs_writedata[4*k +: 4];
                A_CTRL: nCtrl = avs_writedata & CTRL_MASK;
                A_PER:  begin nPer = avs_writedata; nCnt = 0; end
                default: if (avs_writedata[0]) begin nOff = 0; nPh = 1'b0; nCnt = 0; end
            endcase
        end
        @(posedge clk);
        #1;
        mNib = nNib; mCtrl = nCtrl; mPeriod = nPer;
        mCnt = nCnt; mOffset = nOff; mPhase = nPh;
        mExp = nextExp;
        checkOutput("export", {16'd0, seg7_export}, {16'd0, mExp});
        checkOutput("readdata", {32'd0, avs_readdata}, {32'd0, mRd});
    endtask

    task automatic applyStimulus(input bit w, input bit r, input logic [1:0] a, input logic [31:0] d);
        avs_write     = w;
        avs_read      = r;
        avs_address   = a;
        avs_writedata = d;
        stepCycle();
        avs_write = 1'b0;
        avs_read  = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, A_DATA, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; avs_address = 2'd0; avs_write = 1'b0; avs_writedata = 32'd0; avs_read = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetExport", {16'd0, seg7_export}, {16'd0, 48'hFFFF_FFFF_FFFF});
        checkOutput("resetReaddata", {32'd0, avs_readdata}, 64'd0);
        reset = 1'b0;

        // Static display
        $display("[TB] static display");
        applyStimulus(1'b1, 1'b0, A_DATA, 32'h0054_3210);
        applyStimulus(1'b1, 1'b0, A_CTRL, 32'h1);
        idle();
        checkOutput("static", {16'd0, seg7_export}, {16'd0, 48'h9299B0A4F9C0});

        // Scroll up by one per tick
        $display("[TB] scroll");
        applyStimulus(1'b1, 1'b0, A_PER, 32'd4);
        applyStimulus(1'b1, 1'b0, A_CTRL, 32'h5);
        n = 0;
        while (mOffset != 1 && n < 40) begin idle(); n++; end
        if (mOffset != 1) timeoutFail("scrollWait");
        idle();
        checkOutput("scroll1", {16'd0, seg7_export}, {16'd0, 48'hC09299B0A4F9});
        applyStimulus(1'b0, 1'b1, A_STAT, 32'd0);
        checkOutput("status1", {32'd0, avs_readdata}, 64'd1);
        n = 0;
        while (mOffset != 0 && n < 60) begin idle(); n++; end
        if (mOffset != 0) timeoutFail("wrapWait");
        idle();
        checkOutput("scrollWrap", {16'd0, seg7_export}, {16'd0, 48'h9299B0A4F9C0});

        // Scroll down: first tick goes to the last digit
        $display("[TB] scroll down");
        applyStimulus(1'b1, 1'b0, A_STAT, 32'h1);
        applyStimulus(1'b1, 1'b0, A_CTRL, 32'hD);
        n = 0;
        while (mOffset == 0 && n < 40) begin idle(); n++; end
        if (mOffset == 0) timeoutFail("dirWait");
        applyStimulus(1'b0, 1'b1, A_STAT, 32'd0);
        checkOutput("dirFirst", {32'd0, avs_readdata}, 64'd5);

        // STATUS clear on the very edge a tick fires
        $display("[TB] clear vs tick");
        n = 0;
        while (!(mCnt == 3 && mOffset != 0) && n < 40) begin idle(); n++; end
        if (!(mCnt == 3 && mOffset != 0)) timeoutFail("collideWait");
        applyStimulus(1'b1, 1'b0, A_STAT, 32'h1);
        applyStimulus(1'b0, 1'b1, A_STAT, 32'd0);
        checkOutput("clrCollide", {32'd0, avs_readdata}, 64'd0);

        // PERIOD 0 behaves as 1: offset moves every cycle
        $display("[TB] period zero");
        applyStimulus(1'b1, 1'b0, A_CTRL, 32'h5);
        applyStimulus(1'b1, 1'b0, A_PER, 32'd0);
        applyStimulus(1'b1, 1'b0, A_STAT, 32'h1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, 1'b1, A_STAT, 32'd0);
            checkOutput("p0seq", {32'd0, avs_readdata}, 64'(k % N));
        end

        // Blink with digit-0 decimal point
        $display("[TB] blink");
        applyStimulus(1'b1, 1'b0, A_PER, 32'd10);
        applyStimulus(1'b1, 1'b0, A_CTRL, 32'h0103);
        applyStimulus(1'b1, 1'b0, A_STAT, 32'h1);
        idle();
        checkOutput("blinkOn", {16'd0, seg7_export}, {16'd0, 48'h9299B0A4F940});
        n = 0;
        while (!mPhase && n < 30) begin idle(); n++; end
        if (!mPhase) timeoutFail("blinkOffWait");
        idle();
        checkOutput("blinkOff", {16'd0, seg7_export}, {16'd0, 48'hFFFF_FFFF_FFFF});
        n = 0;
        while (mPhase && n < 30) begin idle(); n++; end
        if (mPhase) timeoutFail("blinkOnWait");
        idle();
        checkOutput("blinkOnAgain", {16'd0, seg7_export}, {16'd0, 48'h9299B0A4F940});

        // Registered read latency and hold
        $display("[TB] read latency");
        applyStimulus(1'b1, 1'b0, A_CTRL, 32'h0107);
        applyStimulus(1'b0, 1'b1, A_CTRL, 32'd0);
        checkOutput("rdLatency", {32'd0, avs_readdata}, 64'h107);
        idle();
        checkOutput("rdHold", {32'd0, avs_readdata}, 64'h107);

        // Random register traffic against the model
        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            logic [1:0]  a;
            logic [31:0] d;
            bit          w, r;
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == A_PER) d = 32'($urandom_range(0, 5));
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) == 0);
            applyStimulus(w, r, a, d);
        end

        // Asynchronous reset in the middle of scrolling
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0, A_DATA, 32'h00AB_CDEF);
        applyStimulus(1'b1, 1'b0, A_PER, 32'd3);
        applyStimulus(1'b1, 1'b0, A_CTRL, 32'h0305);
        applyStimulus(1'b0, 1'b1, A_DATA, 32'd0);
        repeat (4) idle();
        #3;
        reset = 1'b1;
        #1;
        checkOutput("rstAsyncExport", {16'd0, seg7_export}, {16'd0, 48'hFFFF_FFFF_FFFF});
        checkOutput("rstAsyncReaddata", {32'd0, avs_readdata}, 64'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, A_CTRL, 32'd0);
        checkOutput("rstCtrl", {32'd0, avs_readdata}, 64'd0);
        applyStimulus(1'b0, 1'b1, A_STAT, 32'd0);
        checkOutput("rstStatus", {32'd0, avs_readdata}, 64'd0);
        applyStimulus(1'b0, 1'b1, A_PER, 32'd0);
        checkOutput("rstPeriod", {32'd0, avs_readdata}, {32'd0, DEF_PER});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
